ps2_key_tracker: RTL and testbench

- Parametrised successor to the single-flag scan-code FSM. Consumes bytes from the PS/2 receiver FIFO with its own pop handshake.
- Decodes the E0 (extended) and F0 (break) prefixes into key events.
- Tracks up to SLOTS simultaneously held keys and counts distinct key presses, suppressing typematic repeats.
- Sits between the PS/2 receiver and the seven-segment display logic, and replaces the old display flag with key_down.

---
 rtl/ps2_key_tracker.sv | 152 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver FIFO, decodes E0/F0 prefixes
// into key events, and keeps a small table of held keys with a distinct-press counter.
module ps2_key_tracker #(
  parameter int SLOTS = 4,
  parameter int CNT_W = 8,
  parameter int HW    = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  output logic             ps2_nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             evt_rpt,
  output logic             key_down,
  output logic [HW-1:0]    held_count,
  output logic [7:0]       last_code,
  output logic             last_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             table_ovf
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} dec_state_e;

  logic [7:0]       rx_byte;
  logic             rx_vld;
  dec_state_e       state_q, state_d;
  logic             emit, cur_ext, cur_brk;
  logic [SLOTS-1:0] slot_vld;
  logic [SLOTS-1:0] slot_ext;
  logic [7:0]       slot_code [SLOTS];
  logic             hit_any, free_any, do_ins, do_clr;
  logic [IW-1:0]    hit_idx, free_idx;

  // Pop handshake: the strobe is low for exactly one cycle, so pops are >= 2 cycles apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_nextdata_n <= 1'b1;
      rx_vld         <= 1'b0;
      rx_byte        <= '0;
    end else if (ps2_nextdata_n && ps2_ready) begin
      ps2_nextdata_n <= 1'b0;
      rx_vld         <= 1'b1;
      rx_byte        <= ps2_data;
    end else begin
      ps2_nextdata_n <= 1'b1;
      rx_vld         <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    cur_ext = (state_q == S_EXT) || (state_q == S_EXTBRK);
    cur_brk = (state_q == S_BRK) || (state_q == S_EXTBRK);
    if (rx_vld) begin
      case (rx_byte)
        8'hE0:   state_d = S_EXT;
        8'hF0:   state_d = cur_ext ? S_EXTBRK : S_BRK;
        8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF:
                 state_d = S_IDLE;
        default: begin
          emit    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Parallel match over all slots; the descending scan leaves the lowest free index.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_ext[i] == cur_ext) && (slot_code[i] == rx_byte)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!slot_vld[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign do_ins = emit && !cur_brk && !hit_any && free_any;
  assign do_clr = emit &&  cur_brk &&  hit_any;

  // NOTE: slot payload is not reset; the valid bit alone decides whether a slot means anything.
  always_ff @(posedge clk) begin
    if (do_ins) begin
      slot_ext[free_idx]  <= cur_ext;
      slot_code[free_idx] <= rx_byte;
    end
  end

  // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld    <= '0;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      evt_ext     <= 1'b0;
      evt_brk     <= 1'b0;
      evt_rpt     <= 1'b0;
      held_count  <= '0;
      last_code   <= '0;
      last_ext    <= 1'b0;
      press_count <= '0;
      table_ovf   <= 1'b0;
    end else begin
      evt_valid <= emit;
      if (emit) begin
        evt_code <= rx_byte;
        evt_ext  <= cur_ext;
        evt_brk  <= cur_brk;
        evt_rpt  <= !cur_brk && hit_any;
        if (!cur_brk) begin
          last_code <= rx_byte;
          last_ext  <= cur_ext;
          if (!hit_any) begin
            press_count <= press_count + CNT_W'(1);
            if (!free_any) table_ovf <= 1'b1;
          end
        end
      end
      if (do_ins) begin
        slot_vld[free_idx] <= 1'b1;
        held_count         <= held_count + HW'(1);
      end else if (do_clr) begin
        slot_vld[hit_idx] <= 1'b0;
        held_count        <= held_count - HW'(1);
      end
    end
  end

  assign key_down = (held_count != '0);

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: FIFO emulation, a set-based model of held keys, a per-cycle
// compare of every output, directed scenarios with literal expectations, then random traffic.
module tb_ps2_key_tracker;

  localparam int SLOTS = 4;
  localparam int CNT_W = 8;
  localparam int HW    = $clog2(SLOTS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ps2_data = 8'h00;
  logic             ps2_ready = 1'b0;
  logic             ps2_nextdata_n;
  logic             evt_valid;
  logic [7:0]       evt_code;
  logic             evt_ext, evt_brk, evt_rpt, key_down;
  logic [HW-1:0]    held_count;
  logic [7:0]       last_code;
  logic             last_ext;
  logic [CNT_W-1:0] press_count;
  logic             table_ovf;

  ps2_key_tracker #(.SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata_n(ps2_nextdata_n), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_rpt(evt_rpt), .key_down(key_down),
    .held_count(held_count), .last_code(last_code), .last_ext(last_ext),
    .press_count(press_count), .table_ovf(table_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo [$];
  logic [8:0] held [$];
  logic [1:0] evt_log [$];

  logic             m_ext, m_brk;
  logic             exp_nd, exp_valid, exp_eext, exp_ebrk, exp_rpt, exp_last_ext, exp_ovf;
  logic [7:0]       exp_code, exp_last_code;
  logic [CNT_W-1:0] exp_press;
  logic             have_pending = 1'b0;
  logic [7:0]       pending;
  logic             prev_rst = 1'b1, prev_ready = 1'b0, rst_req = 1'b1, stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    held.delete();
    m_ext = 0; m_brk = 0;
    exp_nd = 1; exp_valid = 0; exp_code = 0; exp_eext = 0; exp_ebrk = 0; exp_rpt = 0;
    exp_last_code = 0; exp_last_ext = 0; exp_press = 0; exp_ovf = 0;
    have_pending = 0;
  endtask

  // Prefix flags: E0 marks extended and forgets any break; F0 marks break; a key or
  // a non-key byte ends the sequence.
  task automatic model_byte(input logic [7:0] b);
    int idx;
    logic [8:0] key;
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      key = {m_ext, b};
      idx = -1;
      foreach (held[i]) if (held[i] == key) idx = i;
      exp_valid = 1; exp_code = b; exp_eext = m_ext; exp_ebrk = m_brk;
      if (m_brk) begin
        exp_rpt = 0;
        if (idx >= 0) held.delete(idx);
      end else begin
        exp_last_code = b; exp_last_ext = m_ext;
        exp_rpt = (idx >= 0);
        if (idx < 0) begin
          exp_press = exp_press + 1'b1;
          if (held.size() < SLOTS) held.push_back(key);
          else exp_ovf = 1;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (prev_rst) model_reset();
    else begin
      exp_nd    = !(prev_ready && exp_nd);
      exp_valid = 0;
      if (have_pending) model_byte(pending);
      have_pending = 0;
    end
    if (!ps2_nextdata_n && fifo.size() > 0) begin
      pending = fifo.pop_front();
      have_pending = 1;
    end
    if (evt_valid === 1'b1) evt_log.push_back({evt_brk, evt_rpt});
    check("nextdata_n",  ps2_nextdata_n, exp_nd);
    check("evt_valid",   evt_valid,      exp_valid);
    check("evt_code",    evt_code,       exp_code);
    check("evt_ext",     evt_ext,        exp_eext);
    check("evt_brk",     evt_brk,        exp_ebrk);
    check("evt_rpt",     evt_rpt,        exp_rpt);
    check("key_down",    key_down,       held.size() != 0);
    check("held_count",  held_count,     held.size());
    check("last_code",   last_code,      exp_last_code);
    check("last_ext",    last_ext,       exp_last_ext);
    check("press_count", press_count,    exp_press);
    check("table_ovf",   table_ovf,      exp_ovf);
    rst       = rst_req;
    ps2_ready = (fifo.size() > 0) && !(stall_en && ($urandom_range(0, 3) == 0));
    ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
    prev_ready = ps2_ready;
    prev_rst   = rst;
  endtask

  task automatic feed(input int n, input logic [39:0] bytes);
    for (int i = 0; i < n; i++) fifo.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo.size() > 0 || have_pending) && n < 400) begin
      tick();
      n++;
    end
    check("drain_done", (fifo.size() == 0) && !have_pending, 1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_req = 1;
    tick();
    tick();
    check("rst_nextdata_n", ps2_nextdata_n, 1);
    check("rst_press",      press_count,    0);
    check("rst_held",       held_count,     0);
    rst_req = 0;
    tick();
    evt_log.delete();
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] pool [8] = '{8'h1C, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h15, 8'h75, 8'h6B};
    logic [7:0] junk [7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    if (r < 12)      return 8'hE0;
    else if (r < 30) return 8'hF0;
    else if (r < 35) return junk[$urandom_range(0, 6)];
    else if (r < 38) return 8'($urandom);
    else             return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Make then break of 1C.
    feed(3, 40'h1CF01C);
    drain();
    check("basic_press",  press_count, 1);
    check("basic_last",   last_code,   8'h1C);
    check("basic_keydn",  key_down,    0);
    check("basic_brk",    evt_brk,     1);
    check("basic_nevt",   evt_log.size(), 2);

    // Typematic repeats.
    do_reset();
    feed(5, 40'h1C1C1CF01C);
    drain();
    check("typ_nevt", evt_log.size(), 4);
    if (evt_log.size() == 4)
      check("typ_brk_rpt", {evt_log[0], evt_log[1], evt_log[2], evt_log[3]}, 8'b00_01_01_10);
    check("typ_press", press_count, 1);
    check("typ_held",  held_count,  0);

    // Plain 75 stays held while extended 75 is made and broken.
    do_reset();
    feed(3, 40'h75E075);
    feed(3, 40'hE0F075);
    drain();
    check("ext_held",  held_count, 1);
    check("ext_press", press_count, 2);
    check("ext_code",  evt_code, 8'h75);
    check("ext_flags", {evt_ext, evt_brk, evt_rpt}, 3'b110);

    // Table overflow.
    do_reset();
    feed(5, 40'h151D242D2C);
    drain();
    check("ovf_held",  held_count, 4);
    check("ovf_flag",  table_ovf,  1);
    check("ovf_press", press_count, 5);
    feed(2, 40'hF02C);
    drain();
    check("ovf_brk_held", held_count, 4);
    check("ovf_brk_evt",  {evt_code, evt_brk}, {8'h2C, 1'b1});

    // Non-key byte inside a prefix sequence.
    do_reset();
    feed(3, 40'hE0AA1C);
    drain();
    check("aa_nevt", evt_log.size(), 1);
    check("aa_ext",  evt_ext, 0);
    check("aa_last", {last_code, last_ext}, {8'h1C, 1'b0});

    // Reset mid-prefix with the FIFO ready.
    do_reset();
    feed(2, 40'hE0F0);
    drain();
    fifo.push_back(8'h1C);
    rst_req = 1;
    tick();
    tick();
    check("midrst_nd",    ps2_nextdata_n, 1);
    check("midrst_outs",  {evt_valid, key_down, table_ovf, last_code}, 0);
    rst_req = 0;
    drain();
    check("midrst_flags", {evt_code, evt_ext, evt_brk}, {8'h1C, 2'b00});
    check("midrst_held",  held_count, 1);

    // Random traffic with FIFO stalls and occasional resets.
    stall_en = 1;
    for (int t = 0; t < 4000; t++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) != 0) fifo.push_back(rand_byte());
      rst_req = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst_req = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
